// File: rtl/axistream_forwarder.sv
// axistream_forwarder: reads an accepted packet out of packet memory and emits it
// as an AXI-Stream master. Reads are credit-limited so that words in flight plus
// words buffered never exceed the 4-entry FIFO, which absorbs TREADY back-pressure.
// Memory timing: a strobe is sampled on the edge after the cycle it is driven, and
// rd_data is valid L = 1 + PESSIMISTIC cycles after that sampling edge.
// Optional feature: define AXISTREAM_FORWARDER_STATS_EN to add the 32-bit pkt_count
// output, which counts forwarder_done pulses (zero-length packets included).
module axistream_forwarder #(
   parameter int DATA_WIDTH  = 128,
   parameter int ADDR_WIDTH  = 8,
   parameter int PESSIMISTIC = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [DATA_WIDTH-1:0] TDATA,
   output logic                  TVALID,
   output logic                  TLAST,
   input  logic                  TREADY,
   output logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
   output logic                  forwarder_rd_en,
   input  logic [DATA_WIDTH-1:0] forwarder_rd_data,
   output logic                  forwarder_done,
   input  logic                  ready_for_forwarder,
   input  logic [ADDR_WIDTH:0]   len_to_forwarder
`ifdef AXISTREAM_FORWARDER_STATS_EN
   ,
   output logic [31:0]           pkt_count
`endif
);

   localparam int LAT    = 1 + PESSIMISTIC;
   localparam int STAGES = LAT;
   localparam int DEPTH  = 4;

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

   typedef struct packed {
      logic                  last;
      logic [DATA_WIDTH-1:0] data;
   } beat_t;

   state_t              state;
   logic [ADDR_WIDTH:0] len_q;
   logic [ADDR_WIDTH:0] issued;
   logic [2:0]          inflight;
   logic [2:0]          count;
   logic [1:0]          wr_ptr;
   logic [1:0]          rd_ptr;
   beat_t               fifo_mem [DEPTH];
   logic [STAGES:0]     vld_pipe;
   logic [STAGES:0]     last_pipe;

   logic                last_now;
   logic                start;
   logic                push;
   logic                pop;
   logic                pop_last;
   logic [3:0]          credits;
   beat_t               head;

   // Credits are the words already requested but not yet handed to the sink.
   assign credits  = {1'b0, inflight} + {1'b0, count};
   assign last_now = (issued == len_q - 1'b1);
   assign start    = (state == IDLE) && ready_for_forwarder && !forwarder_done &&
                     (len_to_forwarder != '0);

   assign forwarder_rd_en   = (state == STREAM) && (issued < len_q) && (credits < 4'd4);
   assign forwarder_rd_addr = issued[ADDR_WIDTH-1:0];

   // vld_pipe[STAGES] lines up with the cycle in which rd_data carries that word.
   assign push     = vld_pipe[STAGES];
   assign head     = fifo_mem[rd_ptr];
   assign TVALID   = (count != 3'd0);
   assign TDATA    = TVALID ? head.data : '0;
   assign TLAST    = TVALID & head.last;
   assign pop      = TVALID & TREADY;
   assign pop_last = pop & head.last;

   // Control: packet acceptance, read issue counting, done pulse on the last pop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         len_q          <= '0;
         issued         <= '0;
         forwarder_done <= 1'b0;
      end else begin
         forwarder_done <= 1'b0;
         case (state)
            IDLE: begin
               // ready is ignored while done is high so the same buffer is not re-sent
               if (ready_for_forwarder && !forwarder_done) begin
                  if (len_to_forwarder == '0) begin
                     forwarder_done <= 1'b1;
                  end else begin
                     state  <= STREAM;
                     len_q  <= len_to_forwarder;
                     issued <= '0;
                  end
               end
            end
            STREAM: begin
               if (forwarder_rd_en) begin
                  issued <= issued + 1'b1;
                  if (last_now) state <= FLUSH;
               end
            end
            FLUSH: ;
            default: state <= IDLE;
         endcase
         if (pop_last) begin
            forwarder_done <= 1'b1;
            state          <= IDLE;
            issued         <= '0;
         end
      end
   end

   // Return tracking and FIFO bookkeeping; a reset drops everything in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_pipe  <= '0;
         last_pipe <= '0;
         inflight  <= '0;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
      end else begin
         vld_pipe  <= {vld_pipe[STAGES-1:0], forwarder_rd_en};
         last_pipe <= {last_pipe[STAGES-1:0], last_now};
         inflight  <= start ? 3'd0 : inflight + {2'b0, forwarder_rd_en} - {2'b0, push};
         count     <= count + {2'b0, push} - {2'b0, pop};
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
      end
   end

   // FIFO storage; contents are only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {last_pipe[STAGES], forwarder_rd_data};
   end

`ifdef AXISTREAM_FORWARDER_STATS_EN
   // Packet statistics: one count per done pulse, wrapping naturally.
   always_ff @(posedge clk) begin
      if (!rst_n)              pkt_count <= '0;
      else if (forwarder_done) pkt_count <= pkt_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_axistream_forwarder.sv
// Bench for axistream_forwarder: packet-memory model with configurable latency,
// queue-based expected-beat model checked every cycle, plus pinned literal cases.
module tb_axistream_forwarder;

   localparam int DW   = 128;
   localparam int AW   = 8;
   localparam int PESS = 1;
   localparam int L    = 1 + PESS;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] TDATA;
   logic          TVALID;
   logic          TLAST;
   logic          TREADY = 1'b0;
   logic [AW-1:0] rd_addr;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          done;
   logic          ready = 1'b0;
   logic [AW:0]   len = '0;

   always #5 clk = ~clk;

   axistream_forwarder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PESSIMISTIC(PESS)) dut (
      .clk(clk), .rst_n(rst_n),
      .TDATA(TDATA), .TVALID(TVALID), .TLAST(TLAST), .TREADY(TREADY),
      .forwarder_rd_addr(rd_addr), .forwarder_rd_en(rd_en), .forwarder_rd_data(rd_data),
      .forwarder_done(done), .ready_for_forwarder(ready), .len_to_forwarder(len)
   );

   // Packet memory: strobe sampled at an edge, data valid L cycles after that edge.
   logic [DW-1:0]        mem [256];
   logic [L:0]           rp_v = '0;
   logic [L:0][AW-1:0]   rp_a = '0;
   logic [DW-1:0]        junk = '0;
   always @(posedge clk) begin
      rp_v <= {rp_v[L-1:0], rd_en};
      rp_a <= {rp_a[L-1:0], rd_addr};
      junk <= {$urandom, $urandom, $urandom, $urandom};
   end
   assign rd_data = rp_v[L] ? mem[rp_a[L]] : junk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model state
   bit            busy, done_next, exp_done, busy_now, exp_rst_vals, first_seen, prev_hold;
   int            next_addr, reads, pops, cur_len, start_cyc;
   logic [DW:0]   expq[$];
   logic [DW:0]   e;
   logic [DW-1:0] prev_data;
   logic          prev_last;
   // Observation logs for the pinned cases
   int            beat_cyc[$];
   logic [DW-1:0] beat_dat[$];
   bit            beat_lst[$];
   int            done_cyc[$];
   int            rd_log[$];

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         busy = 0; done_next = 0; prev_hold = 0; exp_rst_vals = 1;
         reads = 0; pops = 0; expq.delete();
      end else begin
         if (exp_rst_vals) begin
            check("rst_tvalid", TVALID, 0);
            check("rst_tlast", TLAST, 0);
            check("rst_tdata", TDATA, 0);
            check("rst_rd_en", rd_en, 0);
            check("rst_rd_addr", rd_addr, 0);
            check("rst_done", done, 0);
            exp_rst_vals = 0;
         end
         busy_now  = busy;
         exp_done  = done_next;
         done_next = 0;
         check("done", done, exp_done);
         if (done) done_cyc.push_back(cyc);
         if (rd_en) begin
            check("rd_en_busy", busy_now, 1);
            check("rd_addr", rd_addr, next_addr);
            check("rd_addr_range", next_addr < cur_len, 1);
            check("outstanding_le4", (reads + 1 - pops) <= 4, 1);
            rd_log.push_back(int'(rd_addr));
            next_addr++;
            reads++;
         end
         if (prev_hold) begin
            check("tvalid_hold", TVALID, 1);
            check("tdata_hold", TDATA, prev_data);
            check("tlast_hold", TLAST, prev_last);
         end
         if (TVALID) begin
            check("tvalid_busy", busy_now, 1);
            if (busy_now && !first_seen) begin
               first_seen = 1;
               check("first_latency", cyc - start_cyc, 3 + L);
            end
         end
         if (TVALID && TREADY) begin
            check("beat_expected", expq.size() != 0, 1);
            e = (expq.size() != 0) ? expq.pop_front() : '0;
            check("tdata", TDATA, e[DW-1:0]);
            check("tlast", TLAST, e[DW]);
            beat_cyc.push_back(cyc);
            beat_dat.push_back(TDATA);
            beat_lst.push_back(TLAST);
            pops++;
            if (e[DW]) begin
               check("reads_total", reads, cur_len);
               done_next = 1;
               busy = 0;
            end
         end
         // packet acceptance decided at the coming edge
         if (!busy_now && !exp_done && ready) begin
            if (len == '0) done_next = 1;
            else begin
               busy = 1; cur_len = int'(len); next_addr = 0; reads = 0; pops = 0;
               start_cyc = cyc; first_seen = 0;
               for (int i = 0; i < cur_len; i++) expq.push_back({i == cur_len - 1, mem[i]});
            end
         end
         prev_hold = TVALID && !TREADY;
         prev_data = TDATA;
         prev_last = TLAST;
      end
   end

   bit rmode = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      TREADY = rmode ? ($urandom_range(0, 1) == 1) : 1'b1;
   endtask

   task automatic clear_logs();
      beat_cyc.delete(); beat_dat.delete(); beat_lst.delete(); done_cyc.delete(); rd_log.delete();
   endtask

   task automatic fill_random();
      for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Offer a packet and wait for its done pulse; returns in the done cycle.
   task automatic send(input int n, input bit hold_ready);
      int k;
      ready = 1'b1;
      len   = n[AW:0];
      k = 0;
      do begin tick(); k++; end while (!done && k < 5000);
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL done_timeout: no done within %0d cycles for len %0d", k, n);
      end
      if (!hold_ready) ready = 1'b0;
   endtask

   int sum_last;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("init_tvalid", TVALID, 0);
      check("init_done", done, 0);
      repeat (2) tick();

      // len=3, words A,B,C, TREADY high
      rmode = 0;
      mem[0] = 128'hA; mem[1] = 128'hB; mem[2] = 128'hC;
      clear_logs();
      send(3, 0);
      tick();
      check("p3_beats", beat_dat.size(), 3);
      if (beat_dat.size() == 3) begin
         check("p3_d0", beat_dat[0], 128'hA);
         check("p3_d1", beat_dat[1], 128'hB);
         check("p3_d2", beat_dat[2], 128'hC);
         check("p3_l0", beat_lst[0], 0);
         check("p3_l1", beat_lst[1], 0);
         check("p3_l2", beat_lst[2], 1);
         check("p3_consec1", beat_cyc[1] - beat_cyc[0], 1);
         check("p3_consec2", beat_cyc[2] - beat_cyc[1], 1);
         check("p3_done_cnt", done_cyc.size(), 1);
         if (done_cyc.size() == 1) check("p3_done_at", done_cyc[0] - beat_cyc[2], 1);
      end
      check("p3_rd_cnt", rd_log.size(), 3);
      if (rd_log.size() == 3) begin
         check("p3_a0", rd_log[0], 0);
         check("p3_a1", rd_log[1], 1);
         check("p3_a2", rd_log[2], 2);
      end

      // len=1
      mem[0] = 128'h1234_5678;
      clear_logs();
      send(1, 0);
      tick();
      check("p1_beats", beat_dat.size(), 1);
      if (beat_dat.size() == 1) begin
         check("p1_d", beat_dat[0], 128'h1234_5678);
         check("p1_last", beat_lst[0], 1);
      end
      check("p1_rd_cnt", rd_log.size(), 1);
      check("p1_done_cnt", done_cyc.size(), 1);

      // len=256, random back-pressure
      rmode = 1;
      fill_random();
      clear_logs();
      send(256, 0);
      tick();
      check("p256_beats", beat_dat.size(), 256);
      check("p256_reads", rd_log.size(), 256);
      check("p256_done_cnt", done_cyc.size(), 1);

      // len=0
      rmode = 0;
      clear_logs();
      send(0, 0);
      repeat (3) tick();
      check("p0_beats", beat_dat.size(), 0);
      check("p0_reads", rd_log.size(), 0);
      check("p0_done_cnt", done_cyc.size(), 1);

      // back-to-back 2 then 5; ready held through the first done pulse
      for (int i = 0; i < 2; i++) mem[i] = 128'h1000 + i;
      clear_logs();
      send(2, 1);
      for (int i = 0; i < 5; i++) mem[i] = 128'h2000 + i;
      tick();
      send(5, 0);
      tick();
      check("b2b_beats", beat_dat.size(), 7);
      check("b2b_done_cnt", done_cyc.size(), 2);
      if (beat_dat.size() == 7) begin
         sum_last = 0;
         foreach (beat_lst[i]) sum_last += int'(beat_lst[i]);
         check("b2b_last_cnt", sum_last, 2);
         check("b2b_last1", beat_lst[1], 1);
         check("b2b_last6", beat_lst[6], 1);
         check("b2b_d1", beat_dat[1], 128'h1001);
         check("b2b_d2", beat_dat[2], 128'h2000);
         check("b2b_d6", beat_dat[6], 128'h2004);
      end

      // reset during beat 3 of len=8
      fill_random();
      clear_logs();
      ready = 1'b1;
      len   = 9'd8;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (beat_dat.size() == 2 && TVALID) break;
      end
      check("rst_at_beat3", beat_dat.size(), 2);
      rst_n = 1'b0;
      ready = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_rst_tvalid", TVALID, 0);
      check("mid_rst_tdata", TDATA, 0);
      check("mid_rst_rd_en", rd_en, 0);
      check("mid_rst_rd_addr", rd_addr, 0);
      repeat (6) tick();
      check("mid_rst_no_done", done_cyc.size(), 0);
      mem[0] = 128'hBEEF0; mem[1] = 128'hBEEF1;
      clear_logs();
      send(2, 0);
      tick();
      check("post_rst_beats", beat_dat.size(), 2);
      if (beat_dat.size() == 2) check("post_rst_d1", beat_dat[1], 128'hBEEF1);
      if (rd_log.size() == 2) check("post_rst_a0", rd_log[0], 0);
      check("post_rst_reads", rd_log.size(), 2);

      // random packets, random back-pressure, sometimes ready held through done
      rmode = 1;
      for (int p = 0; p < 10; p++) begin
         fill_random();
         send(($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 24)), $urandom_range(0, 1) == 1);
      end
      ready = 1'b0;
      repeat (5) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/axistream_forwarder.md
# axistream_forwarder

Reads an accepted packet out of a packet-filter buffer and emits it as an AXI-Stream master. It sits between `parallel_packetfilts` (forwarder port) and the downstream AXI-Stream sink. For each accepted packet it issues word reads to packet memory and buffers the returned words in a small FIFO so random TREADY back-pressure is absorbed. When the last word is accepted it pulses `forwarder_done` to release the buffer.

## Interface
- DATA_WIDTH, 128, AXI-Stream and packet-memory word width in bits.
- ADDR_WIDTH, 8, packet-memory word-address width.
- PESSIMISTIC, 1, packet-memory read latency selector: L = 1 + PESSIMISTIC cycles.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- TDATA  out  DATA_WIDTH  stream data.
- TVALID  out  1  stream valid.
- TLAST  out  1  marks the final word of a packet.
- TREADY  in  1  sink ready.
- forwarder_rd_addr  out  ADDR_WIDTH  packet-memory word address.
- forwarder_rd_en  out  1  read strobe; one word per asserted cycle.
- forwarder_rd_data  in  DATA_WIDTH  read data, valid L cycles after the strobe.
- forwarder_done  out  1  one-cycle pulse when the packet is fully sent.
- ready_for_forwarder  in  1  an accepted packet is available; held until done.
- len_to_forwarder  in  ADDR_WIDTH+1  packet length in words (0..2^ADDR_WIDTH).

## Operation
- States:
  - IDLE: waits for the packet.
  - STREAM: issues reads while the FIFO drains.
  - FLUSH: all reads issued; waits for the last pop.
- IDLE -> STREAM when ready_for_forwarder=1 and len≠0. On this transition:
  - latch len;
  - clear `issued` and `inflight` counters.
- IDLE with ready_for_forwarder=1 and len=0: pulse forwarder_done next cycle and stay in IDLE. No stream beat is produced.
- rd_en = state==STREAM && issued<len && (inflight + fifo_count) < 4.
  - rd_addr = issued (zero-based word index).
  - issued increments on each rd_en.
- STREAM -> FLUSH when issued reaches len.
- Returned-data tracking:
  - A delay line of length L carries {valid, last} for each strobe; last = (address == len−1).
  - On arrival, rd_data and last are pushed into the 4-entry FIFO.
- FIFO head drives TDATA and TLAST. TVALID = FIFO not empty. Pop on TVALID && TREADY.
- Popping the word with last=1:
  - registers forwarder_done=1 for exactly one cycle;
  - state -> IDLE.
- ready_for_forwarder is ignored in the cycle forwarder_done is high. This prevents re-sending the same packet before the buffer deasserts ready.
- TVALID, once asserted, stays high with TDATA stable until accepted (AXI-Stream rule). The credit scheme guarantees no FIFO overflow.
- Reset:
  - TVALID=0, TLAST=0, TDATA=0, rd_en=0, rd_addr=0, forwarder_done=0;
  - FIFO empty, counters 0, state IDLE.
- Reset mid-packet discards in-flight and buffered words; no done pulse is generated.

## Timing
- ready sampled high at edge E0: first rd_en during cycle E0..E1.
- First TVALID after edge E0+2+L, i.e. E0+3 (PESSIMISTIC=0) or E0+4 (PESSIMISTIC=1).
- With TREADY held high, throughput is one word per cycle. FIFO depth 4 ≥ L+2 covers the round trip.
- forwarder_done rises on the edge after the TLAST handshake and lasts one cycle.
- Earliest start of the next packet: the cycle after the done pulse.
- TREADY low stalls the output. Reads stop once inflight + count = 4 and resume the cycle after a pop.

## Configuration
- Macro AXISTREAM_FORWARDER_STATS_EN.
- Defined: adds output pkt_count (32 bits, reset 0).
  - Increments on each forwarder_done pulse and wraps at 2^32.
  - Zero-length packets count.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- len=3, PESSIMISTIC=1, TREADY=1, words 0xA,0xB,0xC:
  - TDATA A,B,C on three consecutive cycles;
  - TLAST only on C;
  - one done pulse the cycle after C;
  - rd_addr 0,1,2.
- len=1: a single beat with TVALID=TLAST=1, then done; rd_en asserted exactly once.
- len=256 (full buffer), TREADY random 50%:
  - all 256 words in order, no duplicates or drops;
  - TDATA stable while TVALID && !TREADY;
  - never more than 4 reads outstanding.
- len=0 with ready=1: no TVALID, one done pulse, return to IDLE.
- Back-to-back packets (len 2 then 5, ready re-asserted the cycle after done):
  - 7 beats, TLAST on beats 2 and 7, two done pulses;
  - no packet re-sent.
- rst_n low during beat 3 of len=8:
  - outputs return to reset values the next cycle, no done pulse;
  - a subsequent len=2 packet streams correctly from address 0.
